// File: rtl/pdm_pkg.sv
// Shared constants, width helper and PCM sample type for the PDM-to-PCM CIC decimator.
// Pure declarations: no latency and no flow control live here.
package pdm_pkg;

  localparam int CIC_ORDER = 3;
  localparam int DC_SHIFT  = 10;

  function automatic int cic_out_w(input int decim);
    return 2 + CIC_ORDER * $clog2(decim);
  endfunction

  localparam int PCM_W_DEFAULT = cic_out_w(64);

  typedef logic signed [PCM_W_DEFAULT-1:0] pcm_t;

endpackage

// File: rtl/pdm_dc_block.sv
// First-order DC-removal high-pass on CIC strobes; 1 cycle strobe-in to strobe-out.
// No backpressure: every input strobe produces exactly one output strobe.
module pdm_dc_block
  import pdm_pkg::*;
#(
  parameter int W     = 20,
  parameter int SHIFT = DC_SHIFT
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                x_vld_i,
  input  logic signed [W-1:0] x_dat_i,
  output logic                y_vld_o,
  output logic signed [W-1:0] y_dat_o
);

  localparam int IW = W + SHIFT;

  logic signed [IW-1:0] x_ext;
  logic signed [IW-1:0] x_prev_q, x_prev_d;
  logic signed [IW-1:0] y_q, y_d;
  logic                 y_vld_q, y_vld_d;

  always_comb begin
    x_ext    = IW'(x_dat_i);
    x_prev_d = x_prev_q;
    y_d      = y_q;
    y_vld_d  = x_vld_i;
    if (x_vld_i) begin
      x_prev_d = x_ext;
      // Leak term pulls the accumulated output back toward zero.
      y_d      = x_ext - x_prev_q + y_q - (y_q >>> SHIFT);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      x_prev_q <= '0;
      y_q      <= '0;
      y_vld_q  <= 1'b0;
    end else begin
      x_prev_q <= x_prev_d;
      y_q      <= y_d;
      y_vld_q  <= y_vld_d;
    end
  end

  assign y_vld_o = y_vld_q;
  assign y_dat_o = y_q[W-1:0];

endmodule

// File: rtl/pdm_cic_decimator.sv
// 3rd-order CIC decimator, 1-bit PDM to signed PCM; strobe 1 cycle after period end (+1 with PDM_DC_BLOCK_EN).
// No backpressure: din_en_i paces the input, pcm_valid_o is a single-cycle strobe.
module pdm_cic_decimator
  import pdm_pkg::*;
#(
  parameter  int DECIM = 64,
  localparam int OUT_W = cic_out_w(DECIM)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    din_i,
  input  logic                    din_en_i,
  output logic signed [OUT_W-1:0] pcm_out_o,
  output logic                    pcm_valid_o
);

  localparam int CNT_W = $clog2(DECIM);

  typedef logic signed [OUT_W-1:0] acc_t;

  acc_t             x_pcm;
  acc_t             int1_q, int1_d;
  acc_t             int2_q, int2_d;
  acc_t             int3_q, int3_d;
  acc_t             dly1_q, dly1_d;
  acc_t             dly2_q, dly2_d;
  acc_t             dly3_q, dly3_d;
  acc_t             cmb1, cmb2, cmb3;
  acc_t             cic_out_q, cic_out_d;
  logic             cic_vld_q, cic_vld_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             period_end;

  always_comb begin
    x_pcm      = din_i ? acc_t'(1) : acc_t'(-1);
    period_end = din_en_i && (cnt_q == CNT_W'(DECIM - 1));

    // Wrapping integrators; modulo arithmetic is undone exactly by the combs.
    int1_d = int1_q;
    int2_d = int2_q;
    int3_d = int3_q;
    cnt_d  = cnt_q;
    if (din_en_i) begin
      int1_d = int1_q + x_pcm;
      int2_d = int2_q + int1_d;
      int3_d = int3_q + int2_d;
      cnt_d  = cnt_q + CNT_W'(1);
    end

    cmb1 = int3_d - dly1_q;
    cmb2 = cmb1   - dly2_q;
    cmb3 = cmb2   - dly3_q;

    dly1_d    = dly1_q;
    dly2_d    = dly2_q;
    dly3_d    = dly3_q;
    cic_out_d = cic_out_q;
    cic_vld_d = period_end;
    if (period_end) begin
      dly1_d    = int3_d;
      dly2_d    = cmb1;
      dly3_d    = cmb2;
      cic_out_d = cmb3;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      int1_q    <= '0;
      int2_q    <= '0;
      int3_q    <= '0;
      dly1_q    <= '0;
      dly2_q    <= '0;
      dly3_q    <= '0;
      cnt_q     <= '0;
      cic_out_q <= '0;
      cic_vld_q <= 1'b0;
    end else begin
      int1_q    <= int1_d;
      int2_q    <= int2_d;
      int3_q    <= int3_d;
      dly1_q    <= dly1_d;
      dly2_q    <= dly2_d;
      dly3_q    <= dly3_d;
      cnt_q     <= cnt_d;
      cic_out_q <= cic_out_d;
      cic_vld_q <= cic_vld_d;
    end
  end

`ifdef PDM_DC_BLOCK_EN
  pdm_dc_block #(
    .W     (OUT_W),
    .SHIFT (DC_SHIFT)
  ) u_dc_block (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .x_vld_i (cic_vld_q),
    .x_dat_i (cic_out_q),
    .y_vld_o (pcm_valid_o),
    .y_dat_o (pcm_out_o)
  );
`else
  assign pcm_out_o   = cic_out_q;
  assign pcm_valid_o = cic_vld_q;
`endif

endmodule

// File: tb/tb_pdm_cic_decimator.sv
// Randomized and directed bench for pdm_cic_decimator against a closed-form CIC reference.
// Expected PCM comes from the input history via binomial weights, not from integrator registers.
module tb_pdm_cic_decimator;
  import pdm_pkg::*;

  localparam int DECIM = 64;
  localparam int OUT_W = cic_out_w(DECIM);
  localparam longint FULL = longint'(DECIM) * DECIM * DECIM;
`ifdef PDM_DC_BLOCK_EN
  localparam int FIRST_LAT = DECIM + 2;
`else
  localparam int FIRST_LAT = DECIM + 1;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic din = 1'b0;
  logic din_en = 1'b0;
  pcm_t pcm_out;
  logic pcm_valid;

  pdm_cic_decimator #(.DECIM(DECIM)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .din_i       (din),
    .din_en_i    (din_en),
    .pcm_out_o   (pcm_out),
    .pcm_valid_o (pcm_valid)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference state: full input history since reset and captured period-end sums.
  int     xs[$];
  longint ch[$];
  logic   m_cic_vld = 1'b0, m_dc_vld = 1'b0, exp_vld = 1'b0;
  longint m_cic_out = 0, m_dc_out = 0, dc_xp = 0, dc_yp = 0, exp_out = 0;

  int     cyc_n = 0, since_rst = 0, last_strb = 0, n_strb = 0, exp_gap = 0;
  bit     first_seen = 0, have_last = 0, chk_first = 0, lit_en = 0;
  longint lit_val = 0;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @cycle %0d: got %0d, expected %0d", tag, cyc_n, got, exp);
    end
  endtask

  function automatic longint wrapw(input longint v, input int w);
    longint m, r;
    m = longint'(1) << w;
    r = v % m;
    if (r < 0) r += m;
    if (r >= m / 2) r -= m;
    return r;
  endfunction

  // Triple running sum of the first n inputs: sample k is weighted by C(n-k+1, 2).
  function automatic longint i3_of(input int n);
    longint s = 0;
    for (int k = 0; k < n; k++)
      s += longint'(xs[k]) * longint'(n - k) * longint'(n - k + 1) / 2;
    return s;
  endfunction

  function automatic longint chist(input int back);
    int idx = ch.size() - 1 - back;
    return (idx >= 0) ? ch[idx] : 0;
  endfunction

  task automatic model_step(input logic d, input logic e, input logic r);
    longint x, y;
    if (r) begin
      xs.delete();
      ch.delete();
      m_cic_vld = 0; m_cic_out = 0;
      m_dc_vld  = 0; m_dc_out  = 0;
      dc_xp = 0; dc_yp = 0;
    end else begin
      m_dc_vld = m_cic_vld;
      if (m_cic_vld) begin
        x = m_cic_out;
        y = wrapw(x - dc_xp + dc_yp - (dc_yp >>> DC_SHIFT), OUT_W + DC_SHIFT);
        dc_xp = x;
        dc_yp = y;
        m_dc_out = wrapw(y, OUT_W);
      end
      m_cic_vld = 0;
      if (e) begin
        xs.push_back(d ? 1 : -1);
        if (xs.size() % DECIM == 0) begin
          ch.push_back(i3_of(xs.size()));
          m_cic_out = wrapw(chist(0) - 3 * chist(1) + 3 * chist(2) - chist(3), OUT_W);
          m_cic_vld = 1;
        end
      end
    end
`ifdef PDM_DC_BLOCK_EN
    exp_vld = m_dc_vld;
    exp_out = m_dc_out;
`else
    exp_vld = m_cic_vld;
    exp_out = m_cic_out;
`endif
  endtask

  // One clock: drive on the falling edge, model on the rising edge, sample 1 ns later.
  task automatic cyc(input logic d, input logic e, input logic r);
    @(negedge clk);
    din = d; din_en = e; rst = r;
    @(posedge clk);
    model_step(d, e, r);
    #1;
    cyc_n++;
    chk("pcm_valid", longint'(pcm_valid), longint'(exp_vld));
    chk("pcm_out", longint'(pcm_out), exp_out);
    if (r) begin
      // Cycle 1 is the one that begins at reset release.
      since_rst = 1; first_seen = 0; have_last = 0; n_strb = 0;
    end else begin
      since_rst++;
      if (exp_vld) n_strb++;
      if (pcm_valid) begin
        if (!first_seen && chk_first) chk("first_strobe", since_rst, FIRST_LAT);
        first_seen = 1;
        if (have_last && exp_gap != 0) chk("strobe_gap", cyc_n - last_strb, exp_gap);
        have_last = 1;
        last_strb = cyc_n;
      end
`ifndef PDM_DC_BLOCK_EN
      if (lit_en && exp_vld && n_strb >= 3) chk("steady", longint'(pcm_out), lit_val);
`endif
    end
  endtask

  // mode 0 ones, 1 zeros, 2 alternating, 3 ones at quarter rate, 4 random
  task automatic run_phase(input int mode, input int n, input longint lit,
                           input int gap, input bit first);
    lit_val = lit; exp_gap = gap; chk_first = first; lit_en = (mode <= 3);
    cyc(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < n; i++) begin
      case (mode)
        0:       cyc(1'b1, 1'b1, 1'b0);
        1:       cyc(1'b0, 1'b1, 1'b0);
        2:       cyc((i % 2) == 0, 1'b1, 1'b0);
        3:       cyc(1'b1, (i % 4) == 0, 1'b0);
        default: cyc(1'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 2999) == 0);
      endcase
    end
  endtask

  initial begin
    repeat (3) cyc(1'b0, 1'b0, 1'b1);
    chk("reset_pcm_out", longint'(pcm_out), 0);
    chk("reset_pcm_valid", longint'(pcm_valid), 0);

    run_phase(0, 8 * DECIM + 4, FULL, DECIM, 1'b1);
    run_phase(1, 6 * DECIM + 4, -FULL, DECIM, 1'b1);
    run_phase(2, 6 * DECIM + 4, 0, DECIM, 1'b1);
    run_phase(3, 6 * 4 * DECIM + 8, FULL, 4 * DECIM, 1'b0);

    // Reset with the decimation counter at 30 must discard the partial period.
    run_phase(0, 2 * DECIM + 30, FULL, DECIM, 1'b1);
    cyc(1'b1, 1'b1, 1'b1);
    chk("mid_rst_pcm_out", longint'(pcm_out), 0);
    chk("mid_rst_pcm_valid", longint'(pcm_valid), 0);
    for (int i = 0; i < 5 * DECIM + 4; i++) cyc(1'b1, 1'b1, 1'b0);

    run_phase(4, 20000, 0, 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pdm_cic_decimator.md
# pdm_cic_decimator

Receive-side counterpart to the wavetable PDM test source: converts a 1-bit PDM microphone stream into signed PCM samples with a 3rd-order CIC decimator. Sits directly behind each mic input in the array filter chain. It is also the loopback checker for the on-chip PDM generator: the PDM bit drives `din`, and the resulting PCM is compared with the wavetable value.

## Interface
- `DECIM`, default 64: decimation ratio; power of two, 4..256.
- `OUT_W`, default 20 (derived, not overridden): PCM width, 2 + 3*log2(DECIM).
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `din`  in  1  PDM bit; 1 = +1, 0 = -1.
- `din_en`  in  1  qualifies `din`, one PDM bit per high cycle; tie high when PDM runs at `clk` rate.
- `pcm_out`  out  OUT_W  signed two's-complement PCM sample.
- `pcm_valid`  out  1  single-cycle strobe; `pcm_out` is new on that cycle.

## Operation
- Input mapping: `din` becomes signed ±1, sign-extended to OUT_W.
- Integrators: three cascaded accumulators of OUT_W bits. They update only on cycles with `din_en`=1 and wrap modulo 2^OUT_W. The wrap is intentional; no saturation.
- Decimation counter: 0..DECIM-1, advances on each `din_en` and wraps to 0.
- Comb stage: when `din_en`=1 and the counter is DECIM-1, the 3rd-integrator value is captured. Three cascaded combs, each with differential delay 1, then update with modulo arithmetic. The result is registered into `pcm_out`.
- Output range: ±DECIM^3. +DECIM^3 fits because OUT_W includes 1 guard bit.
- `din_en`=0: all state holds; `pcm_valid`=0.
- Reset, including mid-operation:
  - Integrators, comb delays, counter, `pcm_out` and `pcm_valid` all clear to 0.
  - The first `pcm_valid` follows the DECIM-th `din_en` after `rst` deasserts.
  - Any partial decimation period in progress is discarded.
- Settling: for a constant input applied from reset, the 3rd and later `pcm_valid` samples carry the steady-state value. The first two are transient.

## Timing
- `pcm_valid` rises 1 cycle after the `din_en` cycle that completes a decimation period. It stays high exactly 1 cycle.
- With `din_en` tied high: one pulse every DECIM cycles. The first pulse is at cycle DECIM+1 after reset release.
- `pcm_out` holds its value between strobes.
- Reset values: `pcm_out`=0, `pcm_valid`=0.
- With `PDM_DC_BLOCK_EN` defined: add 1 cycle of latency to both `pcm_valid` and `pcm_out`. Strobe spacing is unchanged.

## Configuration
- Macro `PDM_DC_BLOCK_EN`.
- Defined: CIC output feeds a 1st-order DC-removal high-pass before `pcm_out`:
  - y[n] = x[n] - x[n-1] + y[n-1] - (y[n-1] >>> DC_SHIFT).
  - Internal width OUT_W+DC_SHIFT; output is truncated back to OUT_W.
  - State updates only on CIC output strobes and clears on `rst`.
- Undefined: CIC output drives `pcm_out` directly; no extra register stage.

## Structure
- Package `pdm_pkg`:
  - `CIC_ORDER`=3.
  - `DC_SHIFT`=10.
  - Function `cic_out_w(decim)`, returning 2 + CIC_ORDER*$clog2(decim).
  - Typedef for the signed PCM sample.
- Sub-module `pdm_dc_block`: the DC-removal filter. It has a strobe-in/strobe-out interface and is instantiated only under `PDM_DC_BLOCK_EN`.
- Integrators, combs and counter stay in the top module.

## Test plan
- All-ones `din`, `din_en`=1, DECIM=64, macro off -> `pcm_out`=+262144 from the 3rd strobe on; strobes every 64 cycles.
- All-zeros `din` -> `pcm_out`=-262144 from the 3rd strobe on. Alternating 1,0 -> `pcm_out`=0 from the 3rd strobe on.
- `din_en` high one cycle in four, all ones -> same values as the first case; strobe spacing 256 cycles; no strobe while `din_en`=0.
- `rst` pulsed mid-period (counter at 30) -> next cycle `pcm_out`=0, no strobe; the first strobe arrives 65 cycles after release. Values then re-settle exactly as from power-up.
- Loopback with the wavetable PDM generator running for 1,000,000 cycles -> integrator wrap causes no glitch. PCM tracks the scaled wavetable within the expected CIC droop.
- Macro on, all-ones input -> first strobe at cycle 66. Output peaks near +262144, then decays monotonically toward 0 with time constant ~1024 strobes.
